master_req_tracker: RTL
=======================

MASTER_REQ_TRACKER -- requirements
Module: master_req_tracker

Interface
REQ-001 The block SHALL have no parameters.
REQ-002 clk  input  1  single clock; all state changes on posedge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 m0_req, m1_req  input  1  master i request valid.
REQ-005 m0_cmd, m1_cmd  input  1  master i command: 0 read, 1 write.
REQ-006 m0_sel, m1_sel  input  1  master i target slave number (address MSB).
REQ-007 m0_ack, m1_ack  output  1  master i acknowledge.
REQ-008 s0_ack, s1_ack  input  1  slave j acknowledge.
REQ-009 s0_req, s1_req  output  1  slave j request valid.
REQ-010 s0_master, s1_master  output  1  master number currently driving slave j.
REQ-011 stat0, stat1  output  2  master i status: 0 NO_REQ, 1 WAIT, 2 W_ACK, 3 W_DATA.
REQ-012 slave0, slave1  output  1  slave number latched for master i.

Function
REQ-013 Each master SHALL have a registered 4-state FSM whose state is driven directly on stat_i.
REQ-014 NO_REQ: on m_i_req=1, go to WAIT next cycle and latch m_i_cmd into cmd_i and m_i_sel into slave_i.
REQ-015 WAIT: on grant from the arbiter of slave_i, go to W_ACK next cycle; otherwise hold.
REQ-016 W_ACK: while s{slave_i}_ack=0, hold.
REQ-017 W_ACK: on s{slave_i}_ack=1, go to W_DATA if cmd_i=0, or to NO_REQ if cmd_i=1.
REQ-018 W_DATA: SHALL last exactly one cycle, then go to NO_REQ unconditionally; m_i_req is ignored during it.
REQ-019 m_i_req SHALL be sampled only in NO_REQ; a request held high after completion starts a new transaction via NO_REQ (minimum 1 idle cycle).
REQ-020 m_i_ack SHALL equal (stat_i==W_ACK) && s{slave_i}_ack, combinationally.
REQ-021 Slave j busy = any master with slave_i==j in W_ACK or W_DATA; this guarantees at most one master awaits read data per slave.
REQ-022 Per slave j, a round-robin arbiter SHALL grant only when slave j is not busy, choosing among masters in WAIT with slave_i==j.
REQ-023 Single contender: that master is granted.
REQ-024 Two contenders: the master equal to the priority pointer prio_j is granted, and prio_j then toggles to the other master.
REQ-025 prio_j SHALL update only on a two-contender grant.
REQ-026 A master in WAIT for slave 0 and another in WAIT for slave 1 SHALL both be granted in the same cycle.
REQ-027 s_j_req SHALL be 1 iff some master is in W_ACK with slave_i==j; s_j_master SHALL name that master, and hold its last value when s_j_req=0.
REQ-028 s_j_ack arriving while s_j_req=0 SHALL be ignored.

Reset
REQ-029 rst_n=0 SHALL immediately, without waiting for clk, force stat0=stat1=NO_REQ, slave0=slave1=0, cmd0=cmd1=0, prio0=prio1=0, s0_master=s1_master=0.
REQ-030 Consequently m0_ack, m1_ack, s0_req and s1_req SHALL read 0 during reset.
REQ-031 Reset asserted mid-transaction SHALL abandon it; after release every FSM starts in NO_REQ.
REQ-032 Reset deassertion SHALL take effect at the first posedge clk after rst_n rises.

Verification
REQ-033 Single read: m0_req=1, cmd=0, sel=1; s1_ack=1 in the 2nd W_ACK cycle.
  -> stat0 sequence 1,2,2,3,0; s1_req=1 in both W_ACK cycles; m0_ack pulses once.
REQ-034 Single write: m1 write to slave 0, s0_ack=1 in the first W_ACK cycle.
  -> stat1 sequence 1,2,0; no W_DATA state.
REQ-035 Contention: both masters request slave 0 in the same cycle, acks immediate, repeated twice.
  -> grant order m0, m1, m0, m1; the second grant occurs only after the first master leaves W_DATA.
REQ-036 Parallel: m0 targets slave 0 and m1 targets slave 1 in the same cycle.
  -> both stat values reach 2 in the same cycle; s0_master=0, s1_master=1.
REQ-037 Reset mid-operation: rst_n=0 while stat0=2 (between clock edges).
  -> stat0=0 and s_req=0 immediately; after release, a fresh request completes normally.
REQ-038 Stray ack: s1_ack=1 with no request pending.
  -> no state change and no m_ack.

Source files
------------

// File: rtl/master_req_tracker.sv
// ---------------------------------------------------------------------------
// MasterReqTracker (module master_req_tracker)
//
// Tracks outstanding requests from two masters to two slaves. Each master has
// a four-state FSM (NO_REQ -> WAIT -> W_ACK -> [W_DATA] -> NO_REQ). Each slave
// has a round-robin arbiter that grants one waiting master at a time, only
// while no other master still owns that slave.
//
// Ports
//   clk                 : single clock, all state changes on the rising edge
//   rst_n               : asynchronous active-low reset
//   m0_req / m1_req     : master request valid
//   m0_cmd / m1_cmd     : master command (0 read, 1 write)
//   m0_sel / m1_sel     : target slave number
//   m0_ack / m1_ack     : acknowledge back to master (combinational)
//   s0_ack / s1_ack     : slave acknowledge
//   s0_req / s1_req     : request valid to slave
//   s0_master/s1_master : master currently driving the slave (holds when idle)
//   stat0 / stat1       : master FSM state (0 NO_REQ, 1 WAIT, 2 W_ACK, 3 W_DATA)
//   slave0 / slave1     : slave number latched for each master
// ---------------------------------------------------------------------------
module master_req_tracker (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       m0_req,
    input  logic       m1_req,
    input  logic       m0_cmd,
    input  logic       m1_cmd,
    input  logic       m0_sel,
    input  logic       m1_sel,
    output logic       m0_ack,
    output logic       m1_ack,
    input  logic       s0_ack,
    input  logic       s1_ack,
    output logic       s0_req,
    output logic       s1_req,
    output logic       s0_master,
    output logic       s1_master,
    output logic [1:0] stat0,
    output logic [1:0] stat1,
    output logic       slave0,
    output logic       slave1
);

    typedef enum logic [1:0] {
        ST_NO_REQ = 2'd0,
        ST_WAIT   = 2'd1,
        ST_W_ACK  = 2'd2,
        ST_W_DATA = 2'd3
    } state_t;

    state_t r_state0;
    state_t r_state1;
    logic   r_cmd0;
    logic   r_cmd1;
    logic   r_slave0;
    logic   r_slave1;
    logic   r_prio0;
    logic   r_prio1;
    logic   r_sMaster0;
    logic   r_sMaster1;

    logic   w_sAckFor0;
    logic   w_sAckFor1;
    logic   w_busy0;
    logic   w_busy1;
    logic   w_cont00;
    logic   w_cont10;
    logic   w_cont01;
    logic   w_cont11;
    logic   w_gnt00;
    logic   w_gnt10;
    logic   w_gnt01;
    logic   w_gnt11;
    logic   w_grant0;
    logic   w_grant1;

    // Next-state rule shared by both master FSMs. A read waits one extra
    // cycle in W_DATA for the returning data; a write finishes on the ack.
    function automatic state_t nextState(input state_t state,
                                         input logic   req,
                                         input logic   grant,
                                         input logic   ack,
                                         input logic   cmd);
        state_t next;
        next = state;
        case (state)
            ST_NO_REQ: if (req)   next = ST_WAIT;
            ST_WAIT:   if (grant) next = ST_W_ACK;
            ST_W_ACK:  if (ack)   next = cmd ? ST_NO_REQ : ST_W_DATA;
            default:              next = ST_NO_REQ;
        endcase
        return next;
    endfunction

    // Ack seen by each master comes from whichever slave it latched.
    assign w_sAckFor0 = r_slave0 ? s1_ack : s0_ack;
    assign w_sAckFor1 = r_slave1 ? s1_ack : s0_ack;

    // A slave stays busy through W_DATA so a second reader cannot be
    // granted while read data for the first is still on its way.
    assign w_busy0 = ((r_state0 == ST_W_ACK || r_state0 == ST_W_DATA) && !r_slave0) ||
                     ((r_state1 == ST_W_ACK || r_state1 == ST_W_DATA) && !r_slave1);
    assign w_busy1 = ((r_state0 == ST_W_ACK || r_state0 == ST_W_DATA) &&  r_slave0) ||
                     ((r_state1 == ST_W_ACK || r_state1 == ST_W_DATA) &&  r_slave1);

    // Contender wires are named w_cont<master><slave>.
    assign w_cont00 = (r_state0 == ST_WAIT) && !r_slave0;
    assign w_cont10 = (r_state1 == ST_WAIT) && !r_slave1;
    assign w_cont01 = (r_state0 == ST_WAIT) &&  r_slave0;
    assign w_cont11 = (r_state1 == ST_WAIT) &&  r_slave1;

    // Round-robin: a lone contender always wins; with two, the pointer decides.
    assign w_gnt00 = !w_busy0 && w_cont00 && (!w_cont10 || !r_prio0);
    assign w_gnt10 = !w_busy0 && w_cont10 && (!w_cont00 ||  r_prio0);
    assign w_gnt01 = !w_busy1 && w_cont01 && (!w_cont11 || !r_prio1);
    assign w_gnt11 = !w_busy1 && w_cont11 && (!w_cont01 ||  r_prio1);

    assign w_grant0 = w_gnt00 | w_gnt01;
    assign w_grant1 = w_gnt10 | w_gnt11;

    // Master FSMs, request capture, priority pointers and slave ownership.
    // The pointer only moves on a contested grant so an uncontested master
    // does not steal the next turn from the other one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state0   <= ST_NO_REQ;
            r_state1   <= ST_NO_REQ;
            r_cmd0     <= 1'b0;
            r_cmd1     <= 1'b0;
            r_slave0   <= 1'b0;
            r_slave1   <= 1'b0;
            r_prio0    <= 1'b0;
            r_prio1    <= 1'b0;
            r_sMaster0 <= 1'b0;
            r_sMaster1 <= 1'b0;
        end else begin
            r_state0 <= nextState(r_state0, m0_req, w_grant0, w_sAckFor0, r_cmd0);
            r_state1 <= nextState(r_state1, m1_req, w_grant1, w_sAckFor1, r_cmd1);

            if (r_state0 == ST_NO_REQ && m0_req) begin
                r_cmd0   <= m0_cmd;
                r_slave0 <= m0_sel;
            end
            if (r_state1 == ST_NO_REQ && m1_req) begin
                r_cmd1   <= m1_cmd;
                r_slave1 <= m1_sel;
            end

            if (!w_busy0 && w_cont00 && w_cont10) r_prio0 <= ~r_prio0;
            if (!w_busy1 && w_cont01 && w_cont11) r_prio1 <= ~r_prio1;

            if (w_gnt00)      r_sMaster0 <= 1'b0;
            else if (w_gnt10) r_sMaster0 <= 1'b1;
            if (w_gnt01)      r_sMaster1 <= 1'b0;
            else if (w_gnt11) r_sMaster1 <= 1'b1;
        end
    end

    // Acks reach a master only in W_ACK, so stray slave acks are dropped.
    assign m0_ack = (r_state0 == ST_W_ACK) && w_sAckFor0;
    assign m1_ack = (r_state1 == ST_W_ACK) && w_sAckFor1;

    assign s0_req = ((r_state0 == ST_W_ACK) && !r_slave0) ||
                    ((r_state1 == ST_W_ACK) && !r_slave1);
    assign s1_req = ((r_state0 == ST_W_ACK) &&  r_slave0) ||
                    ((r_state1 == ST_W_ACK) &&  r_slave1);

    assign s0_master = r_sMaster0;
    assign s1_master = r_sMaster1;
    assign stat0     = r_state0;
    assign stat1     = r_state1;
    assign slave0    = r_slave0;
    assign slave1    = r_slave1;

endmodule
